efpga_op_unit: RTL

EFPGA_OP_UNIT -- requirements
Module: efpga_op_unit

---
 rtl/efpga_op_pkg.sv | 16 +
 rtl/efpga_op_if.sv | 24 ++
 rtl/efpga_op_alu.sv | 51 +++++
 rtl/efpga_op_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/efpga_op_pkg.sv
// Shared encodings for the eFPGA operation unit: operator codes, FSM states,
// and the default datapath width.
package efpga_op_pkg;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_MUL   = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/efpga_op_if.sv
// Core <-> eFPGA operation unit bus: request, operands, results, done and irq.
interface efpga_op_if #(parameter int DATA_W = efpga_op_pkg::DEF_DATA_W);
  logic              en_i;
  logic [1:0]        operator_i;
  logic [1:0]        delay_i;
  logic [DATA_W-1:0] operand_a_i;
  logic [DATA_W-1:0] operand_b_i;
  logic [DATA_W-1:0] result_a_o;
  logic [DATA_W-1:0] result_b_o;
  logic [DATA_W-1:0] result_c_o;
  logic              done_o;
  logic              irq_o;
  logic [4:0]        irq_id_o;
  logic              irq_ack_i;

  modport master (
    output en_i, operator_i, delay_i, operand_a_i, operand_b_i, irq_ack_i,
    input  result_a_o, result_b_o, result_c_o, done_o, irq_o, irq_id_o
  );
  modport slave (
    input  en_i, operator_i, delay_i, operand_a_i, operand_b_i, irq_ack_i,
    output result_a_o, result_b_o, result_c_o, done_o, irq_o, irq_id_o
  );
endinterface

// File: rtl/efpga_op_alu.sv
// Combinational result computation from the captured operator and operands.
module efpga_op_alu
  import efpga_op_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_res_a,
  output logic [DATA_W-1:0] o_res_b,
  output logic [DATA_W-1:0] o_res_c
);
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W-1:0] w_prod;
  logic [4:0]          w_sh;

  // Extra top bit carries out of the add and borrows out of the subtract.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
  assign w_sh   = i_b[4:0];

  always_comb begin
    o_res_a = '0;
    o_res_b = '0;
    o_res_c = '0;
    case (i_op)
      OP_ADD: begin
        o_res_a = w_sum[DATA_W-1:0];
        o_res_b = w_diff[DATA_W-1:0];
        o_res_c = {{(DATA_W-2){1'b0}}, w_diff[DATA_W], w_sum[DATA_W]};
      end
      OP_MUL: begin
        o_res_a = w_prod[DATA_W-1:0];
        o_res_b = w_prod[2*DATA_W-1:DATA_W];
      end
      OP_LOGIC: begin
        o_res_a = i_a & i_b;
        o_res_b = i_a | i_b;
        o_res_c = i_a ^ i_b;
      end
      default: begin
        o_res_a = i_a << w_sh;
        o_res_b = i_a >> w_sh;
        o_res_c = $unsigned($signed(i_a) >>> w_sh);
      end
    endcase
  end
endmodule

// File: rtl/efpga_op_unit.sv
// eFPGA operation unit: IDLE/BUSY/DONE handshake FSM with programmable latency.
// Define EFPGA_OP_IRQ_EN to build the completion interrupt; otherwise irq is tied off.
module efpga_op_unit
  import efpga_op_pkg::*;
#(
  parameter logic [4:0] IRQ_ID = 5'd16,
  parameter int         DATA_W = DEF_DATA_W
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  efpga_op_if.slave  bus
);
  state_t            r_state, w_next;
  logic [1:0]        r_cnt;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_a, r_b;
  logic [DATA_W-1:0] r_res_a, r_res_b, r_res_c;
  logic              r_done;
  logic              w_load, w_dec, w_commit;
  logic [DATA_W-1:0] w_res_a, w_res_b, w_res_c;

  efpga_op_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op   (r_op),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_res_a(w_res_a),
    .o_res_b(w_res_b),
    .o_res_c(w_res_c)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Dropping en_i at any point returns to IDLE; in BUSY that is an abort.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.en_i) w_next = BUSY;
      BUSY:    if (!bus.en_i) w_next = IDLE;
               else if (r_cnt == 2'd0) w_next = DONE;
      DONE:    if (!bus.en_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load   = (r_state == IDLE) && bus.en_i;
    w_dec    = (r_state == BUSY) && bus.en_i && (r_cnt != 2'd0);
    w_commit = (r_state == BUSY) && bus.en_i && (r_cnt == 2'd0);
  end

  // done_o trails the DONE state by one cycle on both rise and fall.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res_a <= '0;
      r_res_b <= '0;
      r_res_c <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt <= bus.delay_i;
        r_op  <= bus.operator_i;
        r_a   <= bus.operand_a_i;
        r_b   <= bus.operand_b_i;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_commit) begin
        r_res_a <= w_res_a;
        r_res_b <= w_res_b;
        r_res_c <= w_res_c;
      end
      r_done <= (r_state == DONE);
    end
  end

  assign bus.result_a_o = r_res_a;
  assign bus.result_b_o = r_res_b;
  assign bus.result_c_o = r_res_c;
  assign bus.done_o     = r_done;

`ifdef EFPGA_OP_IRQ_EN
  logic r_irq;

  // A completion in the same cycle as an ack keeps the request pending.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)           r_irq <= 1'b0;
    else if (w_commit)      r_irq <= 1'b1;
    else if (bus.irq_ack_i) r_irq <= 1'b0;
  end

  assign bus.irq_o    = r_irq;
  assign bus.irq_id_o = r_irq ? IRQ_ID : 5'd0;
`else
  logic w_unused_ack;
  assign w_unused_ack = bus.irq_ack_i;
  assign bus.irq_o    = 1'b0;
  assign bus.irq_id_o = 5'd0;
`endif
endmodule
